// File: rtl/elm_layer_sequencer_if.sv
// elm_layer_sequencer_if
// Bundles every handshake and data signal of the layer sequencer into one
// interface. The widths follow the layer geometry.
//   slave  : the sequencer's view (receives in_*, nrn_out*, out_ready).
//   master : the environment's view (input source, neuron array, consumer).
// Signals:
//   in_data/in_valid/in_ready         input-vector element stream
//   nrn_input/nrn_input_valid         broadcast to every neuron
//   nrn_outvalid/nrn_out              per-neuron result strobes and values
//   out_data/out_valid/out_ready/out_last  serialized result stream
//   busy/frame_done/timeout_err       status
interface elm_layer_sequencer_if #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  parameter int outWidth   = 16
);
  logic [dataWidth-1:0]           in_data;
  logic                           in_valid;
  logic                           in_ready;
  logic [dataWidth-1:0]           nrn_input;
  logic                           nrn_input_valid;
  logic [numNeurons-1:0]          nrn_outvalid;
  logic [numNeurons*outWidth-1:0] nrn_out;
  logic [outWidth-1:0]            out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_last;
  logic                           busy;
  logic                           frame_done;
  logic                           timeout_err;

  modport slave (
    input  in_data, in_valid, nrn_outvalid, nrn_out, out_ready,
    output in_ready, nrn_input, nrn_input_valid, out_data, out_valid,
           out_last, busy, frame_done, timeout_err
  );

  modport master (
    output in_data, in_valid, nrn_outvalid, nrn_out, out_ready,
    input  in_ready, nrn_input, nrn_input_valid, out_data, out_valid,
           out_last, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/elm_layer_sequencer.sv
// elm_layer_sequencer
// Controller for one hidden layer of neurons sharing an input stream.
// Accepts one input vector of numWeight elements, broadcasts each accepted
// element to all neurons one cycle later, collects every neuron's single
// outvalid result into a capture buffer (with a timeout), then serializes the
// results in neuron order over a valid/ready stream.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (also resets the neurons)
//   bus  : elm_layer_sequencer_if.slave, all data/handshake/status signals
module elm_layer_sequencer #(
  parameter int numNeurons    = 30,
  parameter int numWeight     = 128,
  parameter int dataWidth     = 16,
  parameter int outWidth      = 16,
  parameter int timeoutCycles = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  elm_layer_sequencer_if.slave  bus
);

  localparam int BEAT_W = $clog2(numWeight) + 1;
  localparam int TMO_W  = $clog2(timeoutCycles) + 1;
  localparam int IDX_W  = (numNeurons > 1) ? $clog2(numNeurons) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(numWeight - 1);
  localparam logic [TMO_W-1:0]  LAST_TMO  = TMO_W'(timeoutCycles - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(numNeurons - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]            state;
  logic [BEAT_W-1:0]     beat;
  logic [TMO_W-1:0]      tmo;
  logic [IDX_W-1:0]      idx;
  logic [numNeurons-1:0] done;
  logic [outWidth-1:0]   cap [numNeurons];

  logic [dataWidth-1:0]  nrn_input_r;
  logic                  nrn_input_valid_r;
  logic                  frame_done_r;
  logic                  timeout_err_r;

  // Completion must include neurons reporting in this very cycle so that
  // WAIT->DRAIN happens right after the last capture.
  logic [numNeurons-1:0] done_next;
  logic                  all_done;
  logic                  tmo_hit;
  logic                  accept;

  assign done_next = done | bus.nrn_outvalid;
  assign all_done  = &done_next;
  assign tmo_hit   = (tmo == LAST_TMO);

  // Stream-side handshake depends on state only.
  assign bus.in_ready = (state == S_STREAM);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.nrn_input       = nrn_input_r;
  assign bus.nrn_input_valid = nrn_input_valid_r;
  assign bus.busy            = (state != S_IDLE);
  assign bus.frame_done      = frame_done_r;
  assign bus.timeout_err     = timeout_err_r;

  // Output stream is a pure function of state, idx and cap, so it holds
  // steady under backpressure and has no path from out_ready.
  assign bus.out_valid = (state == S_DRAIN);
  assign bus.out_data  = (state == S_DRAIN) ? cap[idx] : '0;
  assign bus.out_last  = (state == S_DRAIN) && (idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      beat              <= '0;
      tmo               <= '0;
      idx               <= '0;
      done              <= '0;
      nrn_input_r       <= '0;
      nrn_input_valid_r <= 1'b0;
      frame_done_r      <= 1'b0;
      timeout_err_r     <= 1'b0;
    end else begin
      // Single-cycle strobes default low every cycle.
      nrn_input_valid_r <= 1'b0;
      frame_done_r      <= 1'b0;

      case (state)
        S_IDLE: begin
          // The element presented now is not consumed; it is taken in STREAM.
          if (bus.in_valid) state <= S_STREAM;
        end

        S_STREAM: begin
          if (accept) begin
            nrn_input_r       <= bus.in_data;
            nrn_input_valid_r <= 1'b1;
            beat              <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state <= S_WAIT;
              tmo   <= '0;
            end
          end
        end

        S_WAIT: begin
          done <= done_next;
          if (all_done) begin
            state <= S_DRAIN;
          end else if (tmo_hit) begin
            timeout_err_r <= 1'b1;
            state         <= S_DRAIN;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        S_DRAIN: begin
          if (bus.out_ready) begin
            if (idx == LAST_IDX) begin
              state        <= S_IDLE;
              frame_done_r <= 1'b1;
              idx          <= '0;
              done         <= '0;
              beat         <= '0;
              tmo          <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture buffer. Several neurons may report in one cycle; a repeat report
  // overwrites. On timeout, neurons that never reported read back as zero so
  // stale results from an earlier frame never leak downstream.
  // NOTE: this small register array is cleared by reset on purpose; it is
  // flops, not a RAM macro, so the reset costs nothing structurally.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < numNeurons; i++) cap[i] <= '0;
    end else if (state == S_WAIT) begin
      for (int i = 0; i < numNeurons; i++) begin
        if (bus.nrn_outvalid[i]) begin
          cap[i] <= bus.nrn_out[i*outWidth +: outWidth];
        end else if (!all_done && tmo_hit && !done[i]) begin
          cap[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_elm_layer_sequencer.sv
// tb_elm_layer_sequencer
// Randomized bench for elm_layer_sequencer with a small layer (4 neurons,
// 4-element vectors, 8-cycle timeout). Each frame is described by an input
// vector and a neuron-stub schedule (report delays and values relative to the
// last broadcast beat). Expected results come from that schedule: the layer
// completes at the latest first report if that is inside the timeout window,
// otherwise at the window end; each neuron's result is its latest report at or
// before completion, or zero.
module tb_elm_layer_sequencer;
  localparam int NN  = 4;
  localparam int NW  = 4;
  localparam int DW  = 8;
  localparam int OW  = 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elm_layer_sequencer_if #(.numNeurons(NN), .dataWidth(DW), .outWidth(OW)) bus ();

  elm_layer_sequencer #(
    .numNeurons(NN), .numWeight(NW), .dataWidth(DW), .outWidth(OW),
    .timeoutCycles(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Frame description and expectations.
  logic [DW-1:0] vec    [NW];
  int            first_d  [NN];
  int            second_d [NN];
  logic [OW-1:0] v1     [NN];
  logic [OW-1:0] v2     [NN];
  logic [OW-1:0] exp_out[NN];
  int            exp_c;
  bit            exp_tmo;
  bit            exp_err;
  int            in_mode;
  int            out_mode;
  int            t_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  task automatic build_expect();
    bit all_in = 1'b1;
    int mx = 0;
    for (int i = 0; i < NN; i++) begin
      if (first_d[i] == 0 || first_d[i] > TMO - 1) all_in = 1'b0;
      else if (first_d[i] > mx) mx = first_d[i];
    end
    exp_tmo = !all_in;
    exp_c   = all_in ? mx : TMO - 1;
    for (int i = 0; i < NN; i++) begin
      exp_out[i] = '0;
      if (first_d[i] != 0 && first_d[i] <= exp_c) exp_out[i] = v1[i];
      if (second_d[i] != 0 && second_d[i] <= exp_c) exp_out[i] = v2[i];
    end
    if (exp_tmo) exp_err = 1'b1;
  endtask

  task automatic rand_frame(input bit allow_tmo);
    for (int w = 0; w < NW; w++) vec[w] = DW'($urandom);
    for (int i = 0; i < NN; i++) begin
      first_d[i]  = $urandom_range(1, 7);
      v1[i]       = OW'($urandom_range(1, 255));
      v2[i]       = OW'($urandom_range(1, 255));
      second_d[i] = ($urandom_range(0, 2) == 0) ? first_d[i] + $urandom_range(1, 5) : 0;
    end
    if (allow_tmo && $urandom_range(0, 2) == 0) begin
      int j = $urandom_range(0, NN - 1);
      // Either silent forever or reporting only after the window closed.
      first_d[j]  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(8, 10);
      second_d[j] = 0;
    end
  endtask

  task automatic drive_inputs();
    int sent = 0;
    int n = 0;
    bit v, acc;
    while (sent < NW && n < 300) begin
      case (in_mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? vec[sent] : DW'($urandom);
      acc = v && bus.in_ready;
      @(posedge clk); #1; n++;
      if (acc) sent++;
    end
    bus.in_valid = 1'b0;
    check("in_beats_sent", sent, NW);
  endtask

  task automatic monitor_stub();
    int cnt = 0;
    int n = 0;
    int extra = 0;
    logic [NN*OW-1:0] nout;
    logic [NN-1:0]    nval;
    while (cnt < NW && n < 300) begin
      if (bus.nrn_input_valid) begin
        check("nrn_input", bus.nrn_input, vec[cnt]);
        cnt++;
      end
      if (cnt < NW) begin
        @(posedge clk); #1; n++;
      end
    end
    check("nrn_beats", cnt, NW);
    t_last = cyc;
    check("wait_in_ready", bus.in_ready, 0);
    check("wait_busy", bus.busy, 1);
    for (int d = 1; d <= 12; d++) begin
      @(posedge clk); #1;
      if (bus.nrn_input_valid) extra++;
      nval = '0;
      nout = (NN*OW)'({$urandom, $urandom});
      for (int i = 0; i < NN; i++) begin
        if (first_d[i] == d) begin
          nval[i] = 1'b1;
          nout[i*OW +: OW] = v1[i];
        end
        if (second_d[i] == d) begin
          nval[i] = 1'b1;
          nout[i*OW +: OW] = v2[i];
        end
      end
      bus.nrn_outvalid = nval;
      bus.nrn_out      = nout;
    end
    @(posedge clk); #1;
    bus.nrn_outvalid = '0;
    check("nrn_valid_extra", extra, 0);
  endtask

  task automatic consume();
    int k = 0;
    int n = 0;
    int stall = 0;
    bit first = 1'b1;
    bit pend = 1'b0;
    bit rdy;
    logic [OW-1:0] pdata = '0;
    while (k < NN && n < 400) begin
      case (out_mode)
        0:       rdy = 1'b1;
        1:       rdy = !(k == 1 && stall < 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (bus.out_valid) begin
        if (first) begin
          check("drain_start", cyc - t_last, exp_c + 1);
          first = 1'b0;
        end
        if (pend) check("out_stable", bus.out_data, pdata);
        if (rdy) begin
          check("out_data", bus.out_data, exp_out[k]);
          check("out_last", bus.out_last, (k == NN - 1));
          k++;
          pend = 1'b0;
        end else begin
          pend  = 1'b1;
          pdata = bus.out_data;
          if (k == 1) stall++;
        end
      end
      @(posedge clk); #1; n++;
    end
    bus.out_ready = 1'b0;
    check("out_count", k, NN);
    check("frame_done", bus.frame_done, 1);
    check("busy_idle", bus.busy, 0);
    check("timeout_err", bus.timeout_err, exp_err);
    @(posedge clk); #1;
    check("frame_done_pulse", bus.frame_done, 0);
    check("out_valid_idle", bus.out_valid, 0);
  endtask

  task automatic run_frame();
    build_expect();
    fork
      drive_inputs();
      monitor_stub();
      consume();
    join
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_nrn_input"}, bus.nrn_input, 0);
    check({tag, "_nrn_input_valid"}, bus.nrn_input_valid, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int sent, n;
    bit acc;
    rst = 1'b1;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.nrn_outvalid = '0;
    bus.nrn_out = '0;
    bus.out_ready = 1'b0;
    exp_err = 1'b0;
    t_last = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single frame, no bubbles, all neurons report together.
    for (int w = 0; w < NW; w++) vec[w] = DW'(w + 1);
    for (int i = 0; i < NN; i++) begin
      first_d[i] = 5; second_d[i] = 0;
      v1[i] = OW'(8'h11 * (i + 1)); v2[i] = '0;
    end
    in_mode = 0; out_mode = 0;
    run_frame();

    // 2: input bubbles, random reports.
    rand_frame(1'b0);
    in_mode = 1; out_mode = 0;
    run_frame();

    // 3: staggered and simultaneous reports; neuron 1 is last.
    rand_frame(1'b0);
    first_d[0] = 2; first_d[1] = 4; first_d[2] = 2; first_d[3] = 3;
    for (int i = 0; i < NN; i++) second_d[i] = 0;
    in_mode = 0; out_mode = 0;
    run_frame();

    // 4: downstream backpressure on index 1.
    rand_frame(1'b0);
    in_mode = 0; out_mode = 1;
    run_frame();

    // 5: timeout, neuron 3 silent.
    rand_frame(1'b0);
    first_d[0] = 1; first_d[1] = 2; first_d[2] = 3; first_d[3] = 0;
    for (int i = 0; i < NN; i++) second_d[i] = 0;
    in_mode = 0; out_mode = 0;
    run_frame();
    repeat (5) @(posedge clk);
    #1;
    check("timeout_sticky", bus.timeout_err, 1);

    // 6: reset after two accepted beats, then a clean frame.
    bus.in_valid = 1'b1;
    sent = 0; n = 0;
    while (sent < 2 && n < 50) begin
      bus.in_data = DW'($urandom);
      acc = bus.in_ready;
      @(posedge clk); #1; n++;
      if (acc) sent++;
    end
    check("reset_beats", sent, 2);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    rst = 1'b0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    rand_frame(1'b0);
    in_mode = 2; out_mode = 2;
    run_frame();

    // Random frames, including timeouts and late/duplicate reports.
    for (int f = 0; f < 15; f++) begin
      rand_frame(1'b1);
      in_mode  = $urandom_range(0, 2);
      out_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      run_frame();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elm_layer_sequencer.md
# elm_layer_sequencer

Controller for one hidden layer of neuron instances that share an input stream. It accepts one input vector of `numWeight` elements and broadcasts it beat by beat to all neurons of the layer. It then collects each neuron's single-cycle `outvalid` result into a capture buffer and serializes the results to the next layer or output stage over a valid/ready stream. It sits between the input-vector source and the neuron array, and again between the neuron array and the downstream consumer.

## Interface
- `numNeurons`, 30: neurons in the layer.
- `numWeight`, 128: elements per input vector; must equal the neurons' `numWeight`.
- `dataWidth`, `` `dataWidth ``: input element width.
- `outWidth`, `` `ROM_bitwidth ``: neuron output width.
- `timeoutCycles`, 64: maximum cycles spent in WAIT.
- `clk`  in  1  clock; one clock domain, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  dataWidth  input vector element.
- `in_valid`  in  1  element valid.
- `in_ready`  out  1  element accepted when `in_valid & in_ready`.
- `nrn_input`  out  dataWidth  broadcast to every neuron `myinput`.
- `nrn_input_valid`  out  1  broadcast to every neuron `myinputValid`.
- `nrn_outvalid`  in  numNeurons  bit i = neuron i `outvalid`.
- `nrn_out`  in  numNeurons*outWidth  neuron i output at bits `[i*outWidth +: outWidth]`.
- `out_data`  out  outWidth  serialized neuron result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accept.
- `out_last`  out  1  high with the result of neuron numNeurons-1.
- `busy`  out  1  state != IDLE.
- `frame_done`  out  1  one-cycle pulse after the last result is accepted.
- `timeout_err`  out  1  sticky; cleared only by `rst`.

## Operation
- **State machine:** IDLE, STREAM, WAIT, DRAIN.
- **IDLE:**
  - `in_ready` = 0.
  - Go to STREAM when `in_valid` = 1. No element is consumed in that cycle.
- **STREAM:**
  - `in_ready` = 1.
  - Each accepted beat is registered onto `nrn_input` with `nrn_input_valid` = 1 in the next cycle.
  - Cycles without an accepted beat drive `nrn_input_valid` = 0 (bubbles allowed). `nrn_input` holds its value.
  - Beat counter (width clog2(numWeight)+1) increments per accepted beat.
  - On the beat where the count reaches numWeight, go to WAIT. `in_ready` drops the following cycle.
- **WAIT:**
  - `in_ready` = 0 and `nrn_input_valid` = 0, which guarantees the falling edge the neurons need to finalize.
  - When `nrn_outvalid[i]` = 1, capture `nrn_out` slice i into `cap[i]` and set `done[i]`. Several bits may assert in the same cycle; all are captured.
  - A second `outvalid` pulse on an already-done neuron overwrites `cap[i]`.
  - When `done` is all ones (including bits set this cycle), go to DRAIN.
  - Timeout counter starts at 0 on entry. If it reaches timeoutCycles-1 without completion:
    - set `timeout_err`;
    - load 0 into `cap` for every neuron not yet done;
    - go to DRAIN.
- **DRAIN:**
  - `out_valid` = 1.
  - `out_data` = `cap[idx]`; `out_last` = (idx == numNeurons-1).
  - On `out_valid & out_ready`, idx increments.
  - On the handshake where `out_last` = 1: go to IDLE, pulse `frame_done` the next cycle, clear `done` and all counters.
  - `out_data` and `out_last` are stable while `out_valid & !out_ready`.
- `nrn_outvalid` pulses outside WAIT are ignored.
- **Reset:** all state returns to IDLE, counters and `done` cleared, `cap` cleared to 0. Outputs reset to 0: `in_ready`, `nrn_input`, `nrn_input_valid`, `out_valid`, `out_data`, `out_last`, `busy`, `frame_done`, `timeout_err`. Reset mid-frame abandons the frame; the neurons are reset by the same `rst`.

## Timing
- Input path: accepted beat to `nrn_input_valid` is 1 cycle.
- Frame input: minimum numWeight+1 cycles from leaving IDLE (one IDLE→STREAM cycle plus numWeight beats).
- WAIT→DRAIN transition takes effect the cycle after the last capture.
- With `out_ready` held high, DRAIN lasts exactly numNeurons cycles.
- `frame_done` is asserted in the first IDLE cycle.
- `in_valid` arriving in that same cycle starts the next frame. Back-to-back frames have no extra dead cycles beyond the IDLE cycle.
- `out_valid`, `out_data` and `out_last` are driven from state and `cap` (no combinational path from `out_ready`). `in_ready` is a function of state only.

## Test plan
1. **Single frame, no bubbles.** numNeurons=4, numWeight=4, `in_data`=1,2,3,4 back-to-back. Neuron stubs pulse `outvalid` 5 cycles after the last `nrn_input_valid` with outputs 0x11, 0x22, 0x33, 0x44. Required: `nrn_input_valid` high exactly 4 cycles; `out_data` sequence 0x11, 0x22, 0x33, 0x44 with `out_last` on 0x44; one `frame_done` pulse; `timeout_err` = 0.
2. **Input bubbles.** `in_valid` toggles 1,0,1,0,... Required: exactly 4 `nrn_input_valid` cycles with matching data; WAIT entered after the 4th beat.
3. **Staggered and simultaneous outvalid.** Neurons 2 and 0 pulse on the same cycle, then 3, then 1. Required: DRAIN only after neuron 1, output order still 0,1,2,3.
4. **Downstream backpressure.** `out_ready` = 0 for 3 cycles on index 1, then 1. Required: `out_data` = `cap[1]` stable throughout, no skipped or duplicated results.
5. **Timeout.** timeoutCycles=8, neuron 3 never pulses. Required: DRAIN after 8 WAIT cycles, `out_data[3]` = 0, `timeout_err` = 1 until `rst`.
6. **Mid-frame reset.** `rst` asserted after 2 beats. Required: next cycle IDLE with all outputs 0, and a new full frame then completes correctly.
